// File: rtl/gpioemu_host_if.sv
// Job request/response handshake plus peripheral strobe bus for gpioemu_host.
// master = the host block's view, slave = the job source / peripheral side.
interface gpioemu_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_a1;
  logic [23:0] req_a2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_w;
  logic [23:0] rsp_l;
  logic        rsp_ovf;
  logic        rsp_timeout;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in;

  modport master (
    input  req_valid, req_a1, req_a2, rsp_ready, sdata_in,
    output req_ready, rsp_valid, rsp_w, rsp_l, rsp_ovf, rsp_timeout,
           saddress, srd, swr, sdata_out
  );

  modport slave (
    output req_valid, req_a1, req_a2, rsp_ready, sdata_in,
    input  req_ready, rsp_valid, rsp_w, rsp_l, rsp_ovf, rsp_timeout,
           saddress, srd, swr, sdata_out
  );
endinterface

// File: rtl/gpioemu_host.sv
// Runs one multiplier/popcount job on the strobe bus: write A1/A2, start, poll status, read W/L.
// Each bus op is STROBE_CYCLES+2 cycles; rsp_* hold while rsp_ready is low and req_ready is high only when idle.
module gpioemu_host #(
  parameter int STROBE_CYCLES = 2,
  parameter int POLL_LIMIT    = 255
) (
  input  logic           clk,
  input  logic           n_reset,
  gpioemu_host_if.master bus
);
  localparam logic [15:0] ADDR_A1   = 16'h0380;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_L    = 16'h0398;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A1, S_WR_A2, S_WR_GO, S_POLL, S_RD_W, S_RD_L, S_RESP
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_RECOV} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic        poll_hit_q, poll_hit_d;
  logic [23:0] a2_q, a2_d;
  logic [15:0] saddress_q, saddress_d;
  logic [31:0] sdata_out_q, sdata_out_d;
  logic        srd_q, srd_d;
  logic        swr_q, swr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_w_q, rsp_w_d;
  logic [23:0] rsp_l_q, rsp_l_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        is_read;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= S_IDLE;
      phase_q       <= PH_SETUP;
      cnt_q         <= '0;
      poll_cnt_q    <= '0;
      poll_hit_q    <= 1'b0;
      a2_q          <= '0;
      saddress_q    <= '0;
      sdata_out_q   <= '0;
      srd_q         <= 1'b0;
      swr_q         <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_w_q       <= '0;
      rsp_l_q       <= '0;
      rsp_ovf_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      poll_cnt_q    <= poll_cnt_d;
      poll_hit_q    <= poll_hit_d;
      a2_q          <= a2_d;
      saddress_q    <= saddress_d;
      sdata_out_q   <= sdata_out_d;
      srd_q         <= srd_d;
      swr_q         <= swr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_w_q       <= rsp_w_d;
      rsp_l_q       <= rsp_l_d;
      rsp_ovf_q     <= rsp_ovf_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    poll_cnt_d    = poll_cnt_q;
    poll_hit_d    = poll_hit_q;
    a2_d          = a2_q;
    saddress_d    = saddress_q;
    sdata_out_d   = sdata_out_q;
    srd_d         = srd_q;
    swr_d         = swr_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_w_d       = rsp_w_q;
    rsp_l_d       = rsp_l_q;
    rsp_ovf_d     = rsp_ovf_q;
    rsp_timeout_d = rsp_timeout_q;
    is_read       = (state_q == S_POLL) || (state_q == S_RD_W) || (state_q == S_RD_L);

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          // Setup cycle of the A1 write begins right after the acceptance edge.
          state_d       = S_WR_A1;
          phase_d       = PH_SETUP;
          saddress_d    = ADDR_A1;
          sdata_out_d   = {8'h00, bus.req_a1};
          a2_d          = bus.req_a2;
          poll_cnt_d    = '0;
          poll_hit_d    = 1'b0;
          rsp_w_d       = '0;
          rsp_l_d       = '0;
          rsp_ovf_d     = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        case (phase_q)
          PH_SETUP: begin
            phase_d = PH_STROBE;
            cnt_d   = 4'd1;
            srd_d   = is_read;
            swr_d   = ~is_read;
          end

          PH_STROBE: begin
            if (cnt_q >= 4'(STROBE_CYCLES)) begin
              // This edge ends the last strobe-high cycle: read data is sampled here.
              phase_d = PH_RECOV;
              srd_d   = 1'b0;
              swr_d   = 1'b0;
              case (state_q)
                S_POLL: begin
                  if (bus.sdata_in[1:0] == 2'b11) begin
                    poll_hit_d = 1'b1;
                    rsp_ovf_d  = ~bus.sdata_in[0];
                  end else begin
                    poll_cnt_d = poll_cnt_q + 8'd1;
                  end
                end
                S_RD_W:  rsp_w_d = bus.sdata_in;
                S_RD_L:  rsp_l_d = bus.sdata_in[23:0];
                default: ;
              endcase
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end

          default: begin
            // Recovery cycle ends: load address/data for the following op.
            phase_d = PH_SETUP;
            case (state_q)
              S_WR_A1: begin
                state_d     = S_WR_A2;
                saddress_d  = ADDR_A2;
                sdata_out_d = {8'h00, a2_q};
              end
              S_WR_A2: begin
                state_d     = S_WR_GO;
                saddress_d  = ADDR_CTRL;
                sdata_out_d = 32'h0000_0001;
              end
              S_WR_GO: begin
                state_d     = S_POLL;
                saddress_d  = ADDR_CTRL;
                sdata_out_d = '0;
              end
              S_POLL: begin
                if (poll_hit_q) begin
                  state_d     = S_RD_W;
                  saddress_d  = ADDR_W;
                  sdata_out_d = '0;
                end else if (poll_cnt_q >= 8'(POLL_LIMIT)) begin
                  state_d       = S_RESP;
                  rsp_valid_d   = 1'b1;
                  rsp_timeout_d = 1'b1;
                  rsp_w_d       = '0;
                  rsp_l_d       = '0;
                  rsp_ovf_d     = 1'b0;
                end
              end
              S_RD_W: begin
                state_d     = S_RD_L;
                saddress_d  = ADDR_L;
                sdata_out_d = '0;
              end
              S_RD_L: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
              end
              default: state_d = S_IDLE;
            endcase
          end
        endcase
      end
    endcase
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_w       = rsp_w_q;
  assign bus.rsp_l       = rsp_l_q;
  assign bus.rsp_ovf     = rsp_ovf_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.saddress    = saddress_q;
  assign bus.srd         = srd_q;
  assign bus.swr         = swr_q;
  assign bus.sdata_out   = sdata_out_q;
endmodule

// File: tb/tb_gpioemu_host.sv
// Bench for gpioemu_host: four instances (default, POLL_LIMIT=3, STROBE_CYCLES=1, STROBE_CYCLES=4)
// each with a register-level peripheral model and a per-cycle bus-rule monitor.
`timescale 1ns/1ps
module tb_gpioemu_host;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  logic        req_valid_v [NI];
  logic [23:0] req_a1_v    [NI];
  logic [23:0] req_a2_v    [NI];
  logic        rsp_ready_v [NI];
  logic        req_ready_v [NI];
  logic        rsp_valid_v [NI];
  logic [31:0] rsp_w_v     [NI];
  logic [23:0] rsp_l_v     [NI];
  logic        rsp_ovf_v   [NI];
  logic        rsp_to_v    [NI];
  logic [15:0] saddr_v     [NI];
  logic        srd_v       [NI];
  logic        swr_v       [NI];
  logic [31:0] sdo_v       [NI];
  int          cfg_wait_v  [NI];
  logic [31:0] cfg_w_v     [NI];
  logic [23:0] cfg_l_v     [NI];
  int          nops_v      [NI];
  int          polls_v     [NI];
  int          rdw_v       [NI];
  int          rdl_v       [NI];
  int          viol_v      [NI];
  logic [48:0] log_v       [NI][16];

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int SC = (gi == 2) ? 1 : (gi == 3) ? 4 : 2;
    localparam int PL = (gi == 1) ? 3 : 255;

    gpioemu_host_if u_if ();
    gpioemu_host #(.STROBE_CYCLES(SC), .POLL_LIMIT(PL)) u_dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (u_if)
    );

    assign u_if.req_valid = req_valid_v[gi];
    assign u_if.req_a1    = req_a1_v[gi];
    assign u_if.req_a2    = req_a2_v[gi];
    assign u_if.rsp_ready = rsp_ready_v[gi];
    assign req_ready_v[gi] = u_if.req_ready;
    assign rsp_valid_v[gi] = u_if.rsp_valid;
    assign rsp_w_v[gi]     = u_if.rsp_w;
    assign rsp_l_v[gi]     = u_if.rsp_l;
    assign rsp_ovf_v[gi]   = u_if.rsp_ovf;
    assign rsp_to_v[gi]    = u_if.rsp_timeout;
    assign saddr_v[gi]     = u_if.saddress;
    assign srd_v[gi]       = u_if.srd;
    assign swr_v[gi]       = u_if.swr;
    assign sdo_v[gi]       = u_if.sdata_out;

    int mpolls = 0;
    int nops = 0, npolls = 0, nrdw = 0, nrdl = 0;
    int nexcl = 0, nwidth = 0, nstab = 0, nrdz = 0;
    int run = 0;
    logic        prev_st = 1'b0, prev_rd = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [31:0] prev_dat = '0;
    logic [48:0] log_q [16];
    logic        st;
    assign st = u_if.srd | u_if.swr;

    // Peripheral model: status reads 2'b01 until cfg_wait polls have completed, then 2'b11.
    always_comb begin
      u_if.sdata_in = 32'hA5A5_A5A5;
      if (u_if.srd) begin
        case (u_if.saddress)
          16'h03A0: u_if.sdata_in = {30'h0, (mpolls >= cfg_wait_v[gi]) ? 2'b11 : 2'b01};
          16'h0390: u_if.sdata_in = cfg_w_v[gi];
          16'h0398: u_if.sdata_in = {8'hEE, cfg_l_v[gi]};
          default:  u_if.sdata_in = 32'h0;
        endcase
      end
    end

    always @(negedge clk) begin
      if (!n_reset) begin
        prev_st   <= 1'b0;
        prev_rd   <= 1'b0;
        run       <= 0;
        prev_addr <= u_if.saddress;
        prev_dat  <= u_if.sdata_out;
      end else begin
        if (u_if.srd && u_if.swr) nexcl <= nexcl + 1;
        if (st) begin
          if (u_if.saddress != prev_addr || u_if.sdata_out != prev_dat) nstab <= nstab + 1;
          if (u_if.srd && u_if.sdata_out != 32'h0) nrdz <= nrdz + 1;
          if (!prev_st) begin
            log_q[nops % 16] <= {u_if.swr, u_if.saddress, u_if.sdata_out};
            nops <= nops + 1;
            run  <= 1;
            if (u_if.swr && u_if.saddress == 16'h03A0) mpolls <= 0;
            if (u_if.srd && u_if.saddress == 16'h03A0) npolls <= npolls + 1;
            if (u_if.srd && u_if.saddress == 16'h0390) nrdw <= nrdw + 1;
            if (u_if.srd && u_if.saddress == 16'h0398) nrdl <= nrdl + 1;
          end else begin
            run <= run + 1;
          end
        end else if (prev_st) begin
          if (run != SC) nwidth <= nwidth + 1;
          if (prev_rd && prev_addr == 16'h03A0) mpolls <= mpolls + 1;
        end
        prev_st   <= st;
        prev_rd   <= u_if.srd;
        prev_addr <= u_if.saddress;
        prev_dat  <= u_if.sdata_out;
      end
    end

    assign nops_v[gi]  = nops;
    assign polls_v[gi] = npolls;
    assign rdw_v[gi]   = nrdw;
    assign rdl_v[gi]   = nrdl;
    assign viol_v[gi]  = nexcl + nwidth + nstab + nrdz;
    for (genvar gj = 0; gj < 16; gj++) begin : g_log
      assign log_v[gi][gj] = log_q[gj];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called #1 after an edge with the instance idle; returns #1 after the acceptance edge.
  task automatic start_job(input int k, input logic [23:0] a1, input logic [23:0] a2);
    check($sformatf("idle_before_i%0d", k), req_ready_v[k], 1'b1);
    req_valid_v[k] = 1'b1;
    req_a1_v[k]    = a1;
    req_a2_v[k]    = a2;
    @(posedge clk); #1;
    req_valid_v[k] = 1'b0;
    req_a1_v[k]    = 24'hFFFFFF;
    req_a2_v[k]    = 24'hFFFFFF;
    check($sformatf("accepted_i%0d", k), req_ready_v[k], 1'b0);
  endtask

  task automatic wait_rsp(input int k, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid_v[k] && lat < 400);
  endtask

  typedef struct {
    int          inst;
    logic [23:0] a1;
    logic [23:0] a2;
    int          wait_n;
    logic [31:0] w;
    logic [23:0] l;
    int          lat;
    int          polls;
    logic        to;
  } vec_t;

  vec_t        vecs [6];
  logic [48:0] exp_ops [6];

  initial begin
    int k, lat, n0, p0, w0, l0, stable, found;
    logic [31:0] exp_w;
    logic [23:0] exp_l;

    vecs[0] = '{0, 24'h000003, 24'h000005, 0,   32'h0000000F, 24'h000004, 24, 1, 1'b0};
    vecs[1] = '{0, 24'h123456, 24'h000100, 3,   32'h12345600, 24'h000009, 36, 4, 1'b0};
    vecs[2] = '{1, 24'h000007, 24'h000006, 2,   32'h0000002A, 24'h000003, 32, 3, 1'b0};
    vecs[3] = '{2, 24'hFFFFFF, 24'h000001, 0,   32'h00FFFFFF, 24'h000018, 18, 1, 1'b0};
    vecs[4] = '{3, 24'h000010, 24'h000010, 2,   32'h00000100, 24'h000001, 48, 3, 1'b0};
    vecs[5] = '{1, 24'h000002, 24'h000002, 255, 32'h00000004, 24'h000001, 24, 3, 1'b1};

    exp_ops[0] = {1'b1, 16'h0380, 32'h0000_0003};
    exp_ops[1] = {1'b1, 16'h0388, 32'h0000_0005};
    exp_ops[2] = {1'b1, 16'h03A0, 32'h0000_0001};
    exp_ops[3] = {1'b0, 16'h03A0, 32'h0000_0000};
    exp_ops[4] = {1'b0, 16'h0390, 32'h0000_0000};
    exp_ops[5] = {1'b0, 16'h0398, 32'h0000_0000};

    for (int i = 0; i < NI; i++) begin
      req_valid_v[i] = 1'b0;
      req_a1_v[i]    = '0;
      req_a2_v[i]    = '0;
      rsp_ready_v[i] = 1'b1;
      cfg_wait_v[i]  = 0;
      cfg_w_v[i]     = '0;
      cfg_l_v[i]     = '0;
    end
    n_reset = 1'b0;

    @(posedge clk); #1;
    check("rst_req_ready", req_ready_v[0], 1'b1);
    check("rst_rsp_valid", rsp_valid_v[0], 1'b0);
    check("rst_strobes", {srd_v[0], swr_v[0]}, 2'b00);
    check("rst_saddress", saddr_v[0], 16'h0);
    check("rst_rsp_w", rsp_w_v[0], 32'h0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      k = vecs[v].inst;
      cfg_wait_v[k] = vecs[v].wait_n;
      cfg_w_v[k]    = vecs[v].w;
      cfg_l_v[k]    = vecs[v].l;
      n0 = nops_v[k];
      p0 = polls_v[k];
      w0 = rdw_v[k];
      l0 = rdl_v[k];
      exp_w = vecs[v].to ? 32'h0 : vecs[v].w;
      exp_l = vecs[v].to ? 24'h0 : vecs[v].l;
      start_job(k, vecs[v].a1, vecs[v].a2);
      wait_rsp(k, lat);
      check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      check($sformatf("v%0d_rsp_w", v), rsp_w_v[k], exp_w);
      check($sformatf("v%0d_rsp_l", v), rsp_l_v[k], exp_l);
      check($sformatf("v%0d_rsp_ovf", v), rsp_ovf_v[k], 1'b0);
      check($sformatf("v%0d_rsp_timeout", v), rsp_to_v[k], vecs[v].to);
      check($sformatf("v%0d_polls", v), polls_v[k] - p0, vecs[v].polls);
      check($sformatf("v%0d_reads_w", v), rdw_v[k] - w0, vecs[v].to ? 0 : 1);
      check($sformatf("v%0d_reads_l", v), rdl_v[k] - l0, vecs[v].to ? 0 : 1);
      check($sformatf("v%0d_op_count", v), nops_v[k] - n0, 3 + vecs[v].polls + (vecs[v].to ? 0 : 2));
      if (v == 0) begin
        for (int j = 0; j < 6; j++)
          check($sformatf("v0_op%0d", j), log_v[0][(n0 + j) % 16], exp_ops[j]);
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_rsp_dropped", v), rsp_valid_v[k], 1'b0);
      check($sformatf("v%0d_idle_after", v), req_ready_v[k], 1'b1);
    end

    // Response backpressure with a second job waiting.
    cfg_wait_v[0] = 0;
    cfg_w_v[0]    = 32'hCAFE_0001;
    cfg_l_v[0]    = 24'h000007;
    rsp_ready_v[0] = 1'b0;
    start_job(0, 24'h000001, 24'h000001);
    wait_rsp(0, lat);
    check("bp_latency", lat, 24);
    req_valid_v[0] = 1'b1;
    req_a1_v[0]    = 24'h000009;
    req_a2_v[0]    = 24'h000009;
    stable = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid_v[0] && !req_ready_v[0] && rsp_w_v[0] == 32'hCAFE_0001 &&
          rsp_l_v[0] == 24'h000007 && !rsp_to_v[0] && !rsp_ovf_v[0])
        stable++;
    end
    check("bp_hold_cycles", stable, 10);
    cfg_w_v[0]     = 32'h0000_0051;
    cfg_l_v[0]     = 24'h000003;
    rsp_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_rsp_valid", rsp_valid_v[0], 1'b0);
    check("bp_hs_req_ready", req_ready_v[0], 1'b1);
    @(posedge clk); #1;
    check("bp_next_accepted", req_ready_v[0], 1'b0);
    req_valid_v[0] = 1'b0;
    wait_rsp(0, lat);
    check("bp_job2_latency", lat, 24);
    check("bp_job2_rsp_w", rsp_w_v[0], 32'h0000_0051);
    @(posedge clk); #1;

    // Reset asserted while the A2 write strobe is high.
    start_job(0, 24'h000004, 24'h000004);
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(posedge clk); #1;
      if (swr_v[0] && saddr_v[0] == 16'h0388) found = 1;
    end
    check("rst_mid_found_wr_a2", found, 1);
    n_reset = 1'b0;
    #1;
    check("rst_mid_swr", swr_v[0], 1'b0);
    check("rst_mid_srd", srd_v[0], 1'b0);
    check("rst_mid_saddress", saddr_v[0], 16'h0);
    check("rst_mid_sdata_out", sdo_v[0], 32'h0);
    check("rst_mid_req_ready", req_ready_v[0], 1'b1);
    check("rst_mid_rsp_valid", rsp_valid_v[0], 1'b0);
    check("rst_mid_rsp_w", rsp_w_v[0], 32'h0);
    check("rst_mid_rsp_timeout_i1", rsp_to_v[1], 1'b0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(posedge clk); #1;
    check("rst_after_rsp_valid", rsp_valid_v[0], 1'b0);
    cfg_wait_v[0] = 1;
    cfg_w_v[0]    = 32'h0000_0010;
    cfg_l_v[0]    = 24'h000001;
    start_job(0, 24'h000004, 24'h000004);
    wait_rsp(0, lat);
    check("rst_fresh_latency", lat, 28);
    check("rst_fresh_rsp_w", rsp_w_v[0], 32'h0000_0010);
    check("rst_fresh_rsp_l", rsp_l_v[0], 24'h000001);
    @(posedge clk); #1;

    for (int i = 0; i < NI; i++)
      check($sformatf("bus_rules_i%0d", i), viol_v[i], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpioemu_host.md
# gpioemu_host

- Bus initiator for the multiplier/popcount peripheral on the `saddress`/`srd`/`swr` strobe bus.
- Accepts a job `(a1, a2)` on a valid/ready request port, then runs the full bus sequence:
  - write A1 and A2,
  - issue start,
  - poll status,
  - read W and L.
- Returns the results on a valid/ready response port.
- Sits between the system-side job source and the peripheral, replacing software-driven register access.

## Interface

Parameters:
- `STROBE_CYCLES`, default 2 — cycles `srd`/`swr` stay high per bus op; legal range 1..15.
- `POLL_LIMIT`, default 255 — maximum status reads before timeout; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  job request valid.
- `req_ready`  out  1  block idle, job accepted when `req_valid && req_ready` at a clock edge.
- `req_a1`  in  24  multiplicand.
- `req_a2`  in  24  multiplier.
- `rsp_valid`  out  1  result valid; held until accepted.
- `rsp_ready`  in  1  result consumer ready.
- `rsp_w`  out  32  product low word read from 0x0390.
- `rsp_l`  out  24  ones count read from 0x0398.
- `rsp_ovf`  out  1  inverted status bit 0 from the final poll.
- `rsp_timeout`  out  1  status never reached 2'b11 within `POLL_LIMIT` polls.
- `saddress`  out  16  bus address.
- `srd`  out  1  read strobe; the peripheral acts on its rising edge.
- `swr`  out  1  write strobe; the peripheral acts on its rising edge.
- `sdata_out`  out  32  write data driven to the peripheral's `sdata_in`.
- `sdata_in`  in  32  read data from the peripheral's `sdata_out`.

## Operation

**States**
- IDLE → WR_A1 → WR_A2 → WR_GO → POLL → RD_W → RD_L → RESP → IDLE.

**Bus ops, in order**
- WR_A1: address 0x0380, data `{8'h0, a1}`.
- WR_A2: address 0x0388, data `{8'h0, a2}`.
- WR_GO: address 0x03A0, data 32'h1.
- POLL: read 0x03A0.
- RD_W: read 0x0390.
- RD_L: read 0x0398.

**Request capture**
- `req_a1`/`req_a2` are registered at acceptance.
- Later changes on the inputs have no effect on the running job.

**POLL**
- If `sdata_in[1:0]==2'b11`: capture `rsp_ovf = ~sdata_in[0]`, then go to RD_W.
- Otherwise increment the 8-bit poll counter and repeat POLL.
- When the counter reaches `POLL_LIMIT` without a match, go directly to RESP with `rsp_timeout=1`, `rsp_w=0`, `rsp_l=0`, `rsp_ovf=0`.

**Reads**
- RD_W captures all 32 bits of `sdata_in` into `rsp_w`.
- RD_L captures `sdata_in[23:0]` into `rsp_l`.

**Response handshake**
- RESP: `rsp_valid=1`; all `rsp_*` outputs stable until `rsp_valid && rsp_ready` at an edge, then IDLE.
- `req_ready` is 1 only in IDLE.
- A new request is never accepted in the same cycle as a response handshake.

**Bus rules**
- `srd` and `swr` are never high simultaneously.
- `saddress` and `sdata_out` hold their last driven value between ops.
- `sdata_out` is 0 during read ops.

**Reset**
- Values on `n_reset` low, effective immediately:
  - `saddress=0`, `srd=0`, `swr=0`, `sdata_out=0`;
  - `req_ready=1`, `rsp_valid=0`;
  - `rsp_w=0`, `rsp_l=0`, `rsp_ovf=0`, `rsp_timeout=0`;
  - poll counter 0, state IDLE.
- Reset mid-op drops the strobe asynchronously and abandons the job; no response is produced.

## Timing

**Bus op length:** `STROBE_CYCLES+2` cycles.
- Setup, 1 cycle: address and data driven, strobes low.
- Strobe, `STROBE_CYCLES` cycles: `srd` or `swr` high; address and data unchanged.
- Recovery, 1 cycle: strobes low.

**Read data sampling**
- `sdata_in` is sampled at the clock edge that ends the last strobe-high cycle.
- The peripheral therefore has at least 1 cycle after the strobe rising edge to update its output.

**Latency**
- First setup cycle starts the cycle after the acceptance edge.
- With N polls, `rsp_valid` rises at edge `(5+N)*(STROBE_CYCLES+2)` after the acceptance edge.
- Default parameters, one poll: 24 cycles.
- Timeout response: edge `(3+POLL_LIMIT)*(STROBE_CYCLES+2)`.

**Back-to-back jobs**
- After the response handshake edge the block is in IDLE.
- Earliest next acceptance is one edge later.

## Test plan

- **Single job:** `a1=0x000003`, `a2=0x000005`; peripheral model returns status 2'b11 on the first poll, W=0x0000000F, L=4.
  - Expect 6 ops with exact addresses and data.
  - Expect `rsp_valid` at edge 24, `rsp_w=0xF`, `rsp_l=4`, `rsp_ovf=0`, `rsp_timeout=0`.
- **Delayed completion:** status reads 2'b01 for three polls, then 2'b11.
  - Expect 4 POLL reads.
  - Expect `rsp_valid` at edge 36; no W/L read before the 4th poll.
- **Timeout:** `POLL_LIMIT=3`, status stuck at 2'b01.
  - Expect exactly 3 polls and no reads of 0x0390/0x0398.
  - Expect `rsp_timeout=1`, `rsp_w=0`, `rsp_l=0` at edge 24.
- **Backpressure:** hold `rsp_ready=0` for 10 cycles.
  - Expect `rsp_*` stable, `req_ready=0`, and a new `req_valid` ignored.
  - After the handshake, the new job is accepted one edge later.
- **Reset mid-strobe:** assert `n_reset` low while `swr=1` during WR_A2.
  - Expect `swr=0` and all outputs at reset values without a clock edge.
  - After release, `req_ready=1` and a fresh job completes normally.
- **Strobe exclusivity and stretch:** `STROBE_CYCLES=1` and `=4`; check on every cycle:
  - `srd&swr==0`;
  - strobe width exact;
  - address and data stable across setup and strobe.
